// File: rtl/button_debounce_fsm.sv
// button_debounce_fsm: debounces a synchronized button level into a clean level with press/release pulses (define HOLD_REPEAT_EN for hold-to-repeat pulses)
module button_debounce_fsm #(
  parameter int DEBOUNCE_TICKS = 500000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_sync,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);
  localparam int SW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [SW-1:0] LAST = SW'(DEBOUNCE_TICKS - 1);
  typedef enum logic [1:0] {IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE} state_t;
  state_t state, state_n;
  logic [SW-1:0] stab_cnt, stab_n;
  logic level_n, press_n, release_n;
  always_comb begin
    state_n = state;
    stab_n = stab_cnt;
    level_n = btn_level;
    press_n = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE: if (btn_sync) begin
        state_n = CONFIRM_PRESS;
        stab_n = SW'(1);
      end
      CONFIRM_PRESS: if (!btn_sync) begin
        state_n = IDLE;
        stab_n = '0;
      end else if (stab_cnt == LAST) begin
        state_n = HELD;
        stab_n = '0;
        level_n = 1'b1;
        press_n = 1'b1;
      end else stab_n = stab_cnt + 1'b1;
      HELD: if (!btn_sync) begin
        state_n = CONFIRM_RELEASE;
        stab_n = SW'(1);
      end
      CONFIRM_RELEASE: if (btn_sync) begin
        state_n = HELD;
        stab_n = '0;
      end else if (stab_cnt == LAST) begin
        state_n = IDLE;
        stab_n = '0;
        level_n = 1'b0;
        release_n = 1'b1;
      end else stab_n = stab_cnt + 1'b1;
      default: begin
        state_n = IDLE;
        stab_n = '0;
        level_n = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      stab_cnt <= '0;
      btn_level <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state <= state_n;
      stab_cnt <= stab_n;
      btn_level <= level_n;
      press_pulse <= press_n;
      release_pulse <= release_n;
    end
  end
`ifdef HOLD_REPEAT_EN
  localparam int REP_MAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(REP_MAX + 1);
  logic [RW-1:0] rep_cnt, rep_n, rep_inc;
  logic rep_armed, armed_n, repeat_n;
  // Only cycles that stay in HELD count, so a pulse can never land outside HELD;
  // rep_armed selects the first delay versus the later period.
  always_comb begin
    rep_inc = rep_cnt + 1'b1;
    rep_n = rep_cnt;
    armed_n = rep_armed;
    repeat_n = 1'b0;
    if (state == HELD && btn_sync) begin
      repeat_n = rep_inc == (rep_armed ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY));
      rep_n = repeat_n ? '0 : rep_inc;
      armed_n = rep_armed | repeat_n;
    end else if (state_n == IDLE || state == CONFIRM_PRESS) begin
      rep_n = '0;
      armed_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt <= '0;
      rep_armed <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      rep_cnt <= rep_n;
      rep_armed <= armed_n;
      repeat_pulse <= repeat_n;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_button_debounce_fsm.sv
// tb_button_debounce_fsm: scoreboard bench comparing the debouncer against a run-length reference model
module tb_button_debounce_fsm;
  localparam int T = 4, D = 6, P = 3;
  logic clk = 1'b0, reset, btn_sync;
  logic btn_level, press_pulse, release_pulse, repeat_pulse;
  int checks = 0, failures = 0;
  logic [3:0] exp_q[$];
  logic m_level = 1'b0;
  int m_run = 0, m_held = 0;
  always #5 clk = ~clk;
  button_debounce_fsm #(.DEBOUNCE_TICKS(T), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .btn_sync(btn_sync), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
  );
  // Model: a level changes after T consecutive samples of the opposite value;
  // m_held counts samples that confirm an already-settled high level.
  task automatic model(input logic r, input logic b);
    logic pr, rl, rp;
    pr = 1'b0;
    rl = 1'b0;
    rp = 1'b0;
    if (r) begin
      m_level = 1'b0;
      m_run = 0;
      m_held = 0;
    end else if (b != m_level) begin
      m_run++;
      if (m_run == T) begin
        m_level = b;
        pr = b;
        rl = !b;
        m_run = 0;
        m_held = 0;
      end
    end else begin
`ifdef HOLD_REPEAT_EN
      if (m_level && m_run == 0) begin
        m_held++;
        rp = m_held == D || (m_held > D && (m_held - D) % P == 0);
      end
`endif
      m_run = 0;
    end
    exp_q.push_back({m_level, pr, rl, rp});
  endtask
  task automatic drive(input logic r, input logic b);
    @(negedge clk);
    reset = r;
    btn_sync = b;
    model(r, b);
  endtask
  task automatic hold(input logic r, input logic b, input int n);
    repeat (n) drive(r, b);
  endtask
  initial begin
    logic [3:0] e, got;
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = {btn_level, press_pulse, release_pulse, repeat_pulse};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL outputs cycle %0d: level/press/release/repeat got %b want %b", cyc, got, e);
        end
      end
    end
  end
  initial begin
    reset = 1'b1;
    btn_sync = 1'b1;
    hold(1, 1, 3);
    hold(0, 1, 8);
    hold(0, 0, 8);
    hold(0, 1, 10);
    hold(0, 0, 8);
    repeat (5) begin
      hold(0, 1, 3);
      drive(0, 0);
    end
    hold(0, 1, 6);
    hold(0, 0, 3);
    hold(0, 1, 4);
    hold(0, 0, 2);
    drive(1, 0);
    hold(0, 0, 4);
    hold(0, 1, T + 20);
    hold(0, 0, 6);
    repeat (400) begin
      hold($urandom_range(40, 0) == 0, 1'($urandom_range(1, 0)), $urandom_range(T + 3, 1));
    end
    hold(0, 0, T + 2);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending expectations got %0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
